// File: rtl/lfsr_pkg.sv
// Shared constants and helpers for the LFSR generator: tap table and width decode.
package lfsr_pkg;

  localparam int unsigned MAX_LFSR_W = 16;

  // Feedback tap mask for a given width; bit (t-1) is set for each 1-indexed tap t.
  function automatic logic [MAX_LFSR_W-1:0] tap_mask(input logic [4:0] w);
    logic [MAX_LFSR_W-1:0] m;
    case (w)
      5'd2:    m = 16'h0003;
      5'd3:    m = 16'h0006;
      5'd4:    m = 16'h000C;
      5'd5:    m = 16'h0014;
      5'd6:    m = 16'h0030;
      5'd7:    m = 16'h0060;
      5'd8:    m = 16'h00B8;
      5'd9:    m = 16'h0110;
      5'd10:   m = 16'h0240;
      5'd11:   m = 16'h0500;
      5'd12:   m = 16'h0829;
      5'd13:   m = 16'h100D;
      5'd14:   m = 16'h2015;
      5'd15:   m = 16'h6000;
      5'd16:   m = 16'hD008;
      default: m = 16'h0000;
    endcase
    return m;
  endfunction

  // Out-of-range widths fall back to the maximum supported width.
  function automatic logic [4:0] width_sat(input logic [4:0] w, input logic [4:0] maxw);
    return ((w < 5'd2) || (w > maxw)) ? maxw : w;
  endfunction

endpackage

// File: rtl/lfsr_gen_if.sv
// Control/data bundle between a stimulus consumer and the LFSR generator.
interface lfsr_gen_if #(
  parameter int unsigned MAXW = 8,
  parameter int unsigned CNTW = 16
);

  logic            load;
  logic [MAXW-1:0] seed;
  logic [4:0]      width;
  logic            en;
  logic            step_mode;
  logic            q_ready;
  logic [MAXW-1:0] q;
  logic            q_valid;
  logic            bit_out;
  logic [CNTW-1:0] period;
  logic            period_done;
  logic            lockup;

  modport master (
    output load, seed, width, en, step_mode, q_ready,
    input  q, q_valid, bit_out, period, period_done, lockup
  );

  modport slave (
    input  load, seed, width, en, step_mode, q_ready,
    output q, q_valid, bit_out, period, period_done, lockup
  );

endinterface

// File: rtl/lfsr_period_ctr.sv
// Counts steps since the last seed load / return-to-seed and reports the period.
module lfsr_period_ctr #(
  parameter int unsigned W    = 8,
  parameter int unsigned CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr_i,
  input  logic            step_i,
  input  logic [W-1:0]    next_i,
  input  logic [W-1:0]    seed_i,
  output logic [CNTW-1:0] period_o,
  output logic            period_done_o
);

  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [CNTW-1:0] period_q, period_d;
  logic            done_q, done_d;
  logic [CNTW-1:0] cnt_inc_c;

  // Next-state: saturating increment, capture on return-to-seed, clear on load.
  always_comb begin
    cnt_inc_c = (&cnt_q) ? cnt_q : cnt_q + CNTW'(1);
    cnt_d     = cnt_q;
    period_d  = period_q;
    done_d    = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (step_i) begin
      if (next_i == seed_i) begin
        period_d = cnt_inc_c;
        done_d   = 1'b1;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_inc_c;
      end
    end
  end

  // Counter, period and pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      period_q <= '0;
      done_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      period_q <= period_d;
      done_q   <= done_d;
    end
  end

  assign period_o      = period_q;
  assign period_done_o = done_q;

endmodule

// File: rtl/lfsr_gen.sv
// Run-time width-selectable Fibonacci LFSR with seed load, handshake stepping,
// zero-seed guard and period measurement.
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int unsigned MAXW = 8,
  parameter int unsigned CNTW = 16
) (
  input logic       clk,
  input logic       reset_n,
  lfsr_gen_if.slave bus
);

  localparam logic [4:0] MAXW_W = 5'(MAXW);

  logic [MAXW-1:0]       state_q, state_d;
  logic [MAXW-1:0]       seed_q, seed_d;
  logic [4:0]            width_q, width_d;
  logic                  valid_q, valid_d;
  logic                  lockup_q, lockup_d;

  logic [4:0]            width_ld_c;
  logic [MAXW-1:0]       mask_ld_c;
  logic [MAXW-1:0]       mask_q_c;
  logic [MAXW-1:0]       seed_masked_c;
  logic [MAX_LFSR_W-1:0] state_ext_c;
  logic                  fb_c;
  logic [MAXW-1:0]       step_nxt_c;
  logic                  step_c;
  logic                  state_en_c;

  // Width decode, feedback and next-state selection; load takes priority over step.
  always_comb begin
    width_ld_c    = width_sat(bus.width, MAXW_W);
    mask_ld_c     = MAXW'((32'd1 << width_ld_c) - 32'd1);
    mask_q_c      = MAXW'((32'd1 << width_q) - 32'd1);
    seed_masked_c = bus.seed & mask_ld_c;
    state_ext_c   = MAX_LFSR_W'(state_q);
    fb_c          = ^(state_ext_c & tap_mask(width_q));
    step_nxt_c    = MAXW'({state_q, fb_c}) & mask_q_c;
    step_c        = valid_q & bus.en & (bus.step_mode ? bus.q_ready : 1'b1);

    state_d    = state_q;
    seed_d     = seed_q;
    width_d    = width_q;
    valid_d    = valid_q;
    lockup_d   = lockup_q;
    state_en_c = 1'b0;

    if (bus.load) begin
      state_en_c = 1'b1;
      width_d    = width_ld_c;
      valid_d    = 1'b1;
      if (seed_masked_c == '0) begin
        state_d  = MAXW'(1);
        seed_d   = MAXW'(1);
        lockup_d = 1'b1;
      end else begin
        state_d  = seed_masked_c;
        seed_d   = seed_masked_c;
        lockup_d = 1'b0;
      end
    end else if (step_c) begin
      state_en_c = 1'b1;
      state_d    = step_nxt_c;
    end
  end

  // Enable flop for the shift state with async clear to the non-zero reset value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= MAXW'(1);
    end else if (state_en_c) begin
      state_q <= state_d;
    end
  end

  // Configuration and status registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seed_q   <= MAXW'(1);
      width_q  <= MAXW_W;
      valid_q  <= 1'b0;
      lockup_q <= 1'b0;
    end else begin
      seed_q   <= seed_d;
      width_q  <= width_d;
      valid_q  <= valid_d;
      lockup_q <= lockup_d;
    end
  end

  lfsr_period_ctr #(
    .W    (MAXW),
    .CNTW (CNTW)
  ) u_period_ctr (
    .clk           (clk),
    .rst_n         (reset_n),
    .clr_i         (bus.load),
    .step_i        (step_c & ~bus.load),
    .next_i        (step_nxt_c),
    .seed_i        (seed_q),
    .period_o      (bus.period),
    .period_done_o (bus.period_done)
  );

  assign bus.q       = state_q;
  assign bus.q_valid = valid_q;
  assign bus.bit_out = state_q[0];
  assign bus.lockup  = lockup_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed bench for lfsr_gen: an 8-bit and a 16-bit instance on a shared clock.
module tb_lfsr_gen;

  logic clk = 1'b0;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  lfsr_gen_if #(.MAXW(8),  .CNTW(16)) b8 ();
  lfsr_gen_if #(.MAXW(16), .CNTW(16)) b16 ();

  lfsr_gen #(.MAXW(8),  .CNTW(16)) u8  (.clk(clk), .reset_n(reset_n), .bus(b8));
  lfsr_gen #(.MAXW(16), .CNTW(16)) u16 (.clk(clk), .reset_n(reset_n), .bus(b16));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load8(input logic [7:0] s, input logic [4:0] w);
    b8.load  = 1'b1;
    b8.seed  = s;
    b8.width = w;
    tick();
    b8.load  = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    total++; if (b8.q !== 8'h01) begin bad++; $display("FAIL reset_q got=%h exp=01", b8.q); end
    total++; if (b8.q_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", b8.q_valid); end
    total++; if (b8.period !== 16'd0) begin bad++; $display("FAIL reset_period got=%0d exp=0", b8.period); end
    total++; if (b8.period_done !== 1'b0 || b8.lockup !== 1'b0) begin
      bad++; $display("FAIL reset_flags got done=%b lockup=%b exp 0 0", b8.period_done, b8.lockup); end
    total++; if (b8.bit_out !== 1'b1) begin bad++; $display("FAIL reset_bit_out got=%b exp=1", b8.bit_out); end
    reset_n = 1'b1;
    b8.en = 1'b1;
    repeat (3) tick();
    total++; if (b8.q !== 8'h01 || b8.q_valid !== 1'b0) begin
      bad++; $display("FAIL step_before_load got q=%h valid=%b exp 01 0", b8.q, b8.q_valid); end
  endtask

  task automatic test_w4_sequence();
    logic [3:0] exp_seq [15] = '{4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA, 4'h5,
                                  4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1};
    b8.en = 1'b1;
    b8.step_mode = 1'b0;
    load8(8'h01, 5'd4);
    total++; if (b8.q !== 8'h01 || b8.q_valid !== 1'b1) begin
      bad++; $display("FAIL w4_load got q=%h valid=%b exp 01 1", b8.q, b8.q_valid); end
    for (int i = 0; i < 15; i++) begin
      tick();
      total++; if (b8.q !== {4'h0, exp_seq[i]}) begin
        bad++; $display("FAIL w4_step%0d got=%h exp=%h", i + 1, b8.q, exp_seq[i]); end
      if (i == 13) begin
        total++; if (b8.period_done !== 1'b0) begin bad++; $display("FAIL w4_early_done got=1 exp=0"); end
      end
    end
    total++; if (b8.period_done !== 1'b1 || b8.period !== 16'd15) begin
      bad++; $display("FAIL w4_period got done=%b period=%0d exp 1 15", b8.period_done, b8.period); end
    tick();
    total++; if (b8.period_done !== 1'b0 || b8.q !== 8'h02) begin
      bad++; $display("FAIL w4_continue got done=%b q=%h exp 0 02", b8.period_done, b8.q); end
  endtask

  task automatic test_periods();
    int n;
    int exp_p [3] = '{7, 255, 31};
    logic [4:0] ws [3] = '{5'd3, 5'd8, 5'd5};
    b8.en = 1'b1;
    b8.step_mode = 1'b0;
    for (int k = 0; k < 3; k++) begin
      load8(8'h01, ws[k]);
      n = 0;
      do begin tick(); n++; end while (b8.period_done !== 1'b1 && n < 1000);
      total++; if (n != exp_p[k] || int'(b8.period) != exp_p[k]) begin
        bad++; $display("FAIL period_w%0d got steps=%0d period=%0d exp=%0d", ws[k], n, b8.period, exp_p[k]); end
    end
    b8.en = 1'b0;
    b16.en = 1'b1;
    b16.step_mode = 1'b0;
    b16.load = 1'b1; b16.seed = 16'h0001; b16.width = 5'd16;
    tick();
    b16.load = 1'b0;
    n = 0;
    do begin tick(); n++; end while (b16.period_done !== 1'b1 && n < 70000);
    total++; if (n != 65535 || b16.period !== 16'hFFFF) begin
      bad++; $display("FAIL period_w16 got steps=%0d period=%0d exp=65535", n, b16.period); end
    b16.en = 1'b0;
  endtask

  task automatic test_lockup();
    b8.en = 1'b0;
    load8(8'h00, 5'd5);
    total++; if (b8.q !== 8'h01 || b8.lockup !== 1'b1) begin
      bad++; $display("FAIL lockup_zero got q=%h lockup=%b exp 01 1", b8.q, b8.lockup); end
    load8(8'h03, 5'd5);
    total++; if (b8.q !== 8'h03 || b8.lockup !== 1'b0) begin
      bad++; $display("FAIL lockup_clear got q=%h lockup=%b exp 03 0", b8.q, b8.lockup); end
    load8(8'hE0, 5'd5);
    total++; if (b8.q !== 8'h01 || b8.lockup !== 1'b1) begin
      bad++; $display("FAIL lockup_masked got q=%h lockup=%b exp 01 1", b8.q, b8.lockup); end
  endtask

  task automatic test_handshake();
    b8.en = 1'b1;
    b8.step_mode = 1'b1;
    b8.q_ready = 1'b0;
    load8(8'h01, 5'd4);
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (b8.q !== 8'h01) begin bad++; $display("FAIL hs_hold%0d got=%h exp=01", i, b8.q); end
    end
    b8.q_ready = 1'b1;
    tick();
    b8.q_ready = 1'b0;
    total++; if (b8.q !== 8'h02) begin bad++; $display("FAIL hs_one_step got=%h exp=02", b8.q); end
    repeat (2) tick();
    total++; if (b8.q !== 8'h02) begin bad++; $display("FAIL hs_after_pulse got=%h exp=02", b8.q); end
    b8.step_mode = 1'b0;
    tick();
    total++; if (b8.q !== 8'h04) begin bad++; $display("FAIL mode_switch got=%h exp=04", b8.q); end
  endtask

  task automatic test_load_step_and_width();
    int n;
    b8.en = 1'b1;
    b8.step_mode = 1'b0;
    load8(8'hFA, 5'd4);
    total++; if (b8.q !== 8'h0A) begin bad++; $display("FAIL load_wins got=%h exp=0a", b8.q); end
    n = 0;
    do begin tick(); n++; end while (b8.period_done !== 1'b1 && n < 100);
    total++; if (n != 15 || b8.period !== 16'd15) begin
      bad++; $display("FAIL load_ctr_zero got steps=%0d period=%0d exp=15", n, b8.period); end
    b8.en = 1'b0;
    load8(8'h81, 5'd20);
    total++; if (b8.q !== 8'h81) begin bad++; $display("FAIL width20_load got=%h exp=81", b8.q); end
    b8.en = 1'b1;
    tick();
    total++; if (b8.q !== 8'h03) begin bad++; $display("FAIL width20_step got=%h exp=03", b8.q); end
    b8.en = 1'b0;
    load8(8'h81, 5'd1);
    total++; if (b8.q !== 8'h81) begin bad++; $display("FAIL width1_load got=%h exp=81", b8.q); end
  endtask

  task automatic test_reset_mid();
    b8.en = 1'b1;
    b8.step_mode = 1'b0;
    load8(8'h00, 5'd8);
    repeat (4) tick();
    #3;
    reset_n = 1'b0;
    #1;
    total++; if (b8.q !== 8'h01 || b8.q_valid !== 1'b0) begin
      bad++; $display("FAIL reset_mid got q=%h valid=%b exp 01 0", b8.q, b8.q_valid); end
    total++; if (b8.lockup !== 1'b0 || b8.period !== 16'd0) begin
      bad++; $display("FAIL reset_mid_status got lockup=%b period=%0d exp 0 0", b8.lockup, b8.period); end
    #2;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      b8.en = 1'b1; tick();
      b8.en = 1'b0; tick();
    end
    total++; if (b8.q !== 8'h01 || b8.q_valid !== 1'b0) begin
      bad++; $display("FAIL en_after_reset got q=%h valid=%b exp 01 0", b8.q, b8.q_valid); end
  endtask

  initial begin
    reset_n = 1'b0;
    b8.load = 1'b0;  b8.seed = '0;  b8.width = 5'd8;  b8.en = 1'b0;  b8.step_mode = 1'b0;  b8.q_ready = 1'b0;
    b16.load = 1'b0; b16.seed = '0; b16.width = 5'd16; b16.en = 1'b0; b16.step_mode = 1'b0; b16.q_ready = 1'b0;
    test_reset();
    test_w4_sequence();
    test_periods();
    test_lockup();
    test_handshake();
    test_load_step_and_width();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lfsr_gen.md
Name: lfsr_gen

Overview:
- Parametrised Fibonacci LFSR pseudo-random generator. Run-time selectable width 2..MAXW with built-in maximal-length tap table, seed load, free-run or handshake stepping, zero-lockup guard, and period measurement.
- Successor to the fixed 4-stage XOR shift chain.
- Feeds test-pattern and stimulus sources in the lab datapath.

Parameters:
- MAXW, 8, maximum LFSR width; legal range 2..16.
- CNTW, 16, width of the period counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- load  in  1  load seed and width this cycle.
- seed  in  MAXW  seed value; bits at or above the selected width are ignored.
- width  in  5  active width, sampled only on load.
- en  in  1  global step enable.
- step_mode  in  1  0 = free-run (step every en cycle); 1 = handshake (step on en & q_ready).
- q_ready  in  1  consumer accepts q (mode 1 only).
- q  out  MAXW  current state, zero-extended above the active width.
- q_valid  out  1  state valid; high from the first load until reset.
- bit_out  out  1  q[0].
- period  out  CNTW  step count at the last return-to-seed.
- period_done  out  1  one-cycle pulse when the state returns to the seed.
- lockup  out  1  sticky flag: last load had an all-zero masked seed.

Behaviour:
- Reset (async assert, sync release): state = 1, width_q = MAXW, q_valid = 0, period = 0, period_done = 0, lockup = 0, step counter = 0.
- Width decode: width < 2 or width > MAXW is latched as MAXW.
- Load: at edge k, state <= seed masked to width_q, seed_q <= same value, step counter <= 0, q_valid <= 1.
  - q shows the seed after edge k (one-cycle latency).
  - If the masked seed is 0: state and seed_q are set to 1 and lockup is set. A load with a nonzero seed clears lockup.
- Step condition: q_valid & en & (step_mode ? q_ready : 1). No stepping occurs before the first load.
- Step for active width w: next = {s[w-2:0], fb}, where fb = XOR of s[t-1] over the taps t for width w. Bits w..MAXW-1 stay 0.
- Tap table (1-indexed):
  - 2:{2,1}, 3:{3,2}, 4:{4,3}, 5:{5,3}, 6:{6,5}, 7:{7,6}, 8:{8,6,5,4}
  - 9:{9,5}, 10:{10,7}, 11:{11,9}, 12:{12,6,4,1}, 13:{13,4,3,1}, 14:{14,5,3,1}, 15:{15,14}, 16:{16,15,13,4}
- Period counter: increments on every step and saturates at all-ones.
  - When a step produces next == seed_q: period <= counter+1 (saturating), period_done pulses in the following cycle, and the counter restarts at 0.
  - The generator keeps running after a return-to-seed.
- Simultaneous load and step: load wins and no step occurs that cycle.
- Handshake (mode 1): q is held stable while q_valid & !q_ready. Each accepted transfer yields exactly one new value on the next cycle.
- Mode switch: takes effect on the next cycle. State is kept.
- Reset mid-sequence: immediate return to the reset values. q_valid stays 0 until the next load.

Decomposition:
- Package lfsr_pkg holds:
  - MAX_LFSR_W = 16
  - a tap-mask constant function/array indexed by width, returning a 16-bit mask
  - a width_sat function
- Sub-module lfsr_period_ctr: saturating counter, compare against seed_q, pulse generation.
- The core state register reuses flopenr-style enable flops with async active-low clear.

Test Plan:
- W=4, seed 0001, mode 0, en=1 -> q = 0010, 0100, 1001, 0011, 0110, 1101, …; period_done pulses after 15 steps with period = 15.
- W=3, seed 001 -> period = 7. W=8, seed 0x01 -> period = 255. MAXW=16, W=16 -> period = 65535.
- Load seed 0 at W=5 -> q = 00001, lockup = 1. Later load of seed 00011 -> lockup = 0.
- Mode 1, q_ready low for 5 cycles -> q constant. Then pulse q_ready for 1 cycle -> exactly one step.
- Load and step in the same cycle with seed 0x0A, W=4 -> q = 1010 next cycle, counter = 0. width = 20 with MAXW=8 -> behaves as W=8.
- Assert reset_n low mid-run between edges -> q = 1 and q_valid = 0 immediately. en pulses before the next load -> no change.
